// File: rtl/inst_fetch_unit_pkg.sv
// Shared widths, handshake levels, FSM encoding and PC helper for the instruction fetch unit.
package inst_fetch_unit_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic [ADDR_WIDTH-1:0] INST_BYTES = 32'd4;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR  = 32'h0000_0000;
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA  = 32'h0000_0000;

    localparam logic READY       = 1'b1;
    localparam logic UNAVAILABLE = 1'b0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        MISS  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // Sequential PC step; wraps modulo 2^32.
    function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch handshake between the instruction fetch unit (master) and the memory controller (slave).
interface inst_fetch_unit_if;
    import inst_fetch_unit_pkg::*;

    logic                  transmit_to_mem_ctrl;
    logic [ADDR_WIDTH-1:0] inst_addr_to_mem_ctrl;
    logic                  inst_rdy_from_mem_ctrl;
    logic [DATA_WIDTH-1:0] inst_from_mem_ctrl;

    modport master (
        output transmit_to_mem_ctrl,
        output inst_addr_to_mem_ctrl,
        input  inst_rdy_from_mem_ctrl,
        input  inst_from_mem_ctrl
    );

    modport slave (
        input  transmit_to_mem_ctrl,
        input  inst_addr_to_mem_ctrl,
        output inst_rdy_from_mem_ctrl,
        output inst_from_mem_ctrl
    );

endinterface

// File: rtl/inst_fetch_unit_icache_array.sv
// Direct-mapped one-word-per-line instruction cache storage: combinational read, synchronous fill.
module inst_fetch_unit_icache_array
    import inst_fetch_unit_pkg::*;
#(
    parameter int LINES = 128,
    parameter int IW    = $clog2(LINES),
    parameter int TW    = ADDR_WIDTH - 2 - IW
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [IW-1:0]         rd_index,
    output logic                  rd_valid,
    output logic [TW-1:0]         rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  we,
    input  logic [IW-1:0]         wr_index,
    input  logic [TW-1:0]         wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [LINES-1:0]      valid_r;
    logic [TW-1:0]         tag_r  [LINES];
    logic [DATA_WIDTH-1:0] data_r [LINES];

    // Valid bits: the only cache state cleared by reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid_r <= {LINES{1'b0}};
        end else if (we) begin
            valid_r[wr_index] <= 1'b1;
        end
    end

    // Tag and data payload, written on a fill.
    always_ff @(posedge clk_in) begin
        if (we) begin
            tag_r[wr_index]  <= wr_tag;
            data_r[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_r[rd_index];
    assign rd_tag   = tag_r[rd_index];
    assign rd_data  = data_r[rd_index];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC, memory-controller fetch handshake, optional I-cache, queue streaming.
// Build option: define ICACHE_EN to include the direct-mapped instruction cache.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = 32'h0000_0000,
    parameter int                    ICACHE_LINES = 128
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    inst_fetch_unit_if.master      mem_if,
    input  logic                   queue_full_in,
    output logic                   inst_valid_out,
    output logic [DATA_WIDTH-1:0]  inst_out,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    input  logic                   flush_in,
    input  logic [ADDR_WIDTH-1:0]  target_pc_in
);

    fetch_state_e          state_r, state_n;
    logic [ADDR_WIDTH-1:0] pc_r, pc_n;
    logic                  transmit_r, transmit_n;
    logic [ADDR_WIDTH-1:0] addr_r, addr_n;
    logic                  valid_r, valid_n;
    logic [DATA_WIDTH-1:0] inst_r, inst_n;
    logic [ADDR_WIDTH-1:0] pc_out_r, pc_out_n;
    logic [DATA_WIDTH-1:0] hold_r, hold_n;
    logic                  hit_s;
    logic [DATA_WIDTH-1:0] cache_data_s;

`ifdef ICACHE_EN
    localparam int IW = $clog2(ICACHE_LINES);
    localparam int TW = ADDR_WIDTH - 2 - IW;

    logic          rd_valid_s;
    logic [TW-1:0] rd_tag_s;
    logic          fill_s;

    // A ready pulse that loses to a flush or a frozen cycle must not fill.
    assign fill_s = (state_r == MISS) && (mem_if.inst_rdy_from_mem_ctrl == READY) && !flush_in && rdy_in;

    inst_fetch_unit_icache_array #(
        .LINES(ICACHE_LINES)
    ) u_icache (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rd_index (pc_r[2+IW-1:2]),
        .rd_valid (rd_valid_s),
        .rd_tag   (rd_tag_s),
        .rd_data  (cache_data_s),
        .we       (fill_s),
        .wr_index (addr_r[2+IW-1:2]),
        .wr_tag   (addr_r[ADDR_WIDTH-1:2+IW]),
        .wr_data  (mem_if.inst_from_mem_ctrl)
    );

    assign hit_s = rd_valid_s && (rd_tag_s == pc_r[ADDR_WIDTH-1:2+IW]);
`else
    assign hit_s        = 1'b0;
    assign cache_data_s = ZERO_DATA;
`endif

    // Next-state and registered-output decode; flush overrides all state logic.
    always_comb begin
        state_n    = state_r;
        pc_n       = pc_r;
        transmit_n = transmit_r;
        addr_n     = addr_r;
        valid_n    = 1'b0;
        inst_n     = inst_r;
        pc_out_n   = pc_out_r;
        hold_n     = hold_r;
        if (flush_in) begin
            pc_n       = target_pc_in;
            transmit_n = 1'b0;
            state_n    = FETCH;
        end else begin
            case (state_r)
                FETCH: begin
                    if (queue_full_in) begin
                        state_n = FETCH;
                    end else if (hit_s) begin
                        valid_n  = 1'b1;
                        inst_n   = cache_data_s;
                        pc_out_n = pc_r;
                        pc_n     = next_pc(pc_r);
                    end else begin
                        transmit_n = 1'b1;
                        addr_n     = pc_r;
                        state_n    = MISS;
                    end
                end
                MISS: begin
                    if (mem_if.inst_rdy_from_mem_ctrl == READY) begin
                        transmit_n = 1'b0;
                        if (!queue_full_in) begin
                            valid_n  = 1'b1;
                            inst_n   = mem_if.inst_from_mem_ctrl;
                            pc_out_n = pc_r;
                            pc_n     = next_pc(pc_r);
                            state_n  = FETCH;
                        end else begin
                            hold_n  = mem_if.inst_from_mem_ctrl;
                            state_n = HOLD;
                        end
                    end else begin
                        state_n = MISS;
                    end
                end
                HOLD: begin
                    if (!queue_full_in) begin
                        valid_n  = 1'b1;
                        inst_n   = hold_r;
                        pc_out_n = pc_r;
                        pc_n     = next_pc(pc_r);
                        state_n  = FETCH;
                    end else begin
                        state_n = HOLD;
                    end
                end
                default: begin
                    state_n = FETCH;
                end
            endcase
        end
    end

    // State and output registers; reset beats the global enable, which freezes everything.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r    <= FETCH;
            pc_r       <= RESET_PC;
            transmit_r <= 1'b0;
            addr_r     <= ZERO_ADDR;
            valid_r    <= 1'b0;
            inst_r     <= ZERO_DATA;
            pc_out_r   <= ZERO_ADDR;
            hold_r     <= ZERO_DATA;
        end else if (rdy_in) begin
            state_r    <= state_n;
            pc_r       <= pc_n;
            transmit_r <= transmit_n;
            addr_r     <= addr_n;
            valid_r    <= valid_n;
            inst_r     <= inst_n;
            pc_out_r   <= pc_out_n;
            hold_r     <= hold_n;
        end
    end

    assign mem_if.transmit_to_mem_ctrl  = transmit_r;
    assign mem_if.inst_addr_to_mem_ctrl = addr_r;
    assign inst_valid_out               = valid_r;
    assign inst_out                     = inst_r;
    assign pc_out                       = pc_out_r;

endmodule
